bridge_master: RTL

Host-side initiator for the 16-bit Bridge link. It takes single-word commands from on-chip host logic and drives the direction, category, transmission and data lines into the Bridge. For a read it waits for the Bridge's request, samples the returned word and acknowledges it. It then returns a response word or an error to the host logic.

---
 rtl/bridge_pkg.sv | 42 ++++
 rtl/bridge_phase_timer.sv | 41 ++++
 rtl/bridge_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the 16-bit Bridge link: bus direction and category
// encodings, the state sets of the host-side master and of the Bridge itself,
// and the link data width.
// -----------------------------------------------------------------------------
package bridge_pkg;

    localparam int DATA_W  = 16;
    localparam int TIMER_W = 16;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } bus_direction_e;

    typedef enum logic [2:0] {
        SYSTEM  = 3'b000,
        ADDRESS = 3'b001,
        DEBUG   = 3'b100,
        STAT    = 3'b101
    } category_e;

    // Host-side initiator states.
    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WRITE_CHECK,
        READ_WAIT,
        READ_ACK,
        RESPOND
    } master_state_e;

    // Bridge (target) states, shared so models of the far end speak the same terms.
    typedef enum logic [1:0] {
        BR_IDLE,
        BR_RECEIVE,
        BR_PROCESS,
        BR_TRANSMIT
    } bridge_state_e;

endpackage

// File: rtl/bridge_phase_timer.sv
// -----------------------------------------------------------------------------
// bridge_phase_timer
// Saturating cycle counter for the current phase of a Bridge transaction.
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   clear_i   in   restart the count at 0 on the next edge
//   count_o   out  cycles spent in the current phase (0 on the first cycle)
//   expired_o out  high on the last allowed cycle, i.e. LIMIT cycles have
//                  been spent once the current edge is taken
// -----------------------------------------------------------------------------
module bridge_phase_timer
    import bridge_pkg::*;
#(
    parameter int unsigned LIMIT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    output logic [TIMER_W-1:0] count_o,
    output logic               expired_o
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (count_q != '1) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q >= LAST);

endmodule

// File: rtl/bridge_master.sv
// -----------------------------------------------------------------------------
// bridge_master
// Host-side initiator for the 16-bit Bridge link. Accepts one command at a
// time, strobes it onto the Bridge for two cycles, then either checks the
// write acknowledge or waits for, captures and acknowledges read data, and
// finally returns a one-cycle response (data or error) to the host.
//   aClock/aResetN            clock, asynchronous active-low reset
//   aCommandValid/Ready       host command handshake (ready only in IDLE)
//   aCommandDirection/Category/Data   command fields
//   aResponseValid/Data/Error one-cycle completion pulse with result
//   anOutInterface            data to the Bridge (0 outside SEND)
//   aDirection/aCategory      registered command direction/category
//   aTransmission             transaction strobe (SEND state)
//   anInInterface/aRequest/anAcknowledge   Bridge return path
//   anAcknowledgeMaster       master acknowledge of read data
// -----------------------------------------------------------------------------
module bridge_master
    import bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              aClock,
    input  logic              aResetN,
    input  logic              aCommandValid,
    output logic              aCommandReady,
    input  logic              aCommandDirection,
    input  logic [2:0]        aCommandCategory,
    input  logic [DATA_W-1:0] aCommandData,
    output logic              aResponseValid,
    output logic [DATA_W-1:0] aResponseData,
    output logic              aResponseError,
    output logic [DATA_W-1:0] anOutInterface,
    output logic              aDirection,
    output logic [2:0]        aCategory,
    output logic              aTransmission,
    input  logic [DATA_W-1:0] anInInterface,
    input  logic              aRequest,
    input  logic              anAcknowledge,
    output logic              anAcknowledgeMaster
);

    master_state_e      state_q, state_d;
    logic               ready_q;
    bus_direction_e     dir_q;
    logic [2:0]         cat_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               error_q, error_d;
    logic [TIMER_W-1:0] phase_count;
    logic               phase_expired;
    logic               accept;

    // ready_q is a register so it stays low through reset and rises on the
    // first edge afterwards; it otherwise tracks "state is IDLE".
    assign accept = aCommandValid && ready_q;

    // The phase counter restarts on every state change, so SEND can be timed
    // from it and each wait phase gets its own timeout window.
    bridge_phase_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (aClock),
        .rst_n     (aResetN),
        .clear_i   (state_d != state_q),
        .count_o   (phase_count),
        .expired_o (phase_expired)
    );

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        rdata_d = rdata_q;
        error_d = error_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    rdata_d = '0;
                    error_d = 1'b0;
                end
            end
            SEND: begin
                // Strobe is held for exactly two cycles (count 0 and 1).
                if (phase_count == TIMER_W'(1)) begin
                    state_d = (dir_q == READ) ? READ_WAIT : WRITE_CHECK;
                end
            end
            WRITE_CHECK: begin
                error_d = !anAcknowledge;
                state_d = RESPOND;
            end
            READ_WAIT: begin
                // Bridge data-valid: request raised while its acknowledge is low.
                if (aRequest && !anAcknowledge) begin
                    rdata_d = anInInterface;
                    state_d = READ_ACK;
                end else if (phase_expired) begin
                    error_d = 1'b1;
                    state_d = RESPOND;
                end
            end
            READ_ACK: begin
                if (!aRequest) begin
                    state_d = RESPOND;
                end else if (phase_expired) begin
                    error_d = 1'b1;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aClock or negedge aResetN) begin
        if (!aResetN) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            dir_q   <= WRITE;
            cat_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            rdata_q <= rdata_d;
            error_q <= error_d;
            if (accept) begin
                dir_q  <= bus_direction_e'(aCommandDirection);
                cat_q  <= aCommandCategory;
                data_q <= aCommandData;
            end
        end
    end

    // Bus and response outputs decode directly from the state register, so
    // an asynchronous reset clears them immediately.
    assign aCommandReady       = ready_q;
    assign aDirection          = dir_q;
    assign aCategory           = cat_q;
    assign aTransmission       = (state_q == SEND);
    assign anOutInterface      = (state_q == SEND) ? data_q : '0;
    assign anAcknowledgeMaster = (state_q == READ_ACK);
    assign aResponseValid      = (state_q == RESPOND);
    assign aResponseError      = (state_q == RESPOND) && error_q;
    // A read that timed out in READ_ACK may hold captured data; errors report 0.
    assign aResponseData       = ((state_q == RESPOND) && !error_q) ? rdata_q : '0;

endmodule
